// File: rtl/mult_sched_pkg.sv
// ------------------------------------------------------------------
// mult_sched_pkg: shared types and constants for mult_scheduler
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package mult_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_LATENCY = 32;

  // Index width for NREQ requesters; never narrower than one bit.
  function automatic int id_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ------------------------------------------------------------------
// rr_arbiter: combinational one-hot round-robin grant from a pointer
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import mult_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]       req_i,
  input  logic [id_w(NREQ)-1:0] ptr_i,
  output logic [NREQ-1:0]       gnt_o,
  output logic [id_w(NREQ)-1:0] idx_o,
  output logic                  any_o
);

  localparam int ID_W = id_w(NREQ);

  int              pos;
  logic [ID_W-1:0] pos_w;

  // Scan NREQ slots starting at the pointer; the first pending one wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    pos   = 0;
    pos_w = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos   = (int'(ptr_i) + k) % NREQ;
      pos_w = ID_W'(pos);
      if (!any_o && req_i[pos_w]) begin
        any_o        = 1'b1;
        gnt_o[pos_w] = 1'b1;
        idx_o        = pos_w;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mult_scheduler.sv
// ------------------------------------------------------------------
// mult_scheduler: round-robin sharing of one sequential multiplier
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module mult_scheduler
  import mult_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid_i,
  output logic [NREQ-1:0]         req_ready_o,
  input  logic [NREQ*WIDTH-1:0]   req_a_i,
  input  logic [NREQ*WIDTH-1:0]   req_b_i,
  output logic [WIDTH-1:0]        mul_in1_o,
  output logic [WIDTH-1:0]        mul_in2_o,
  input  logic [2*WIDTH-1:0]      mul_prod_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [id_w(NREQ)-1:0]   rsp_id_o,
  output logic [2*WIDTH-1:0]      rsp_prod_o,
  output logic                    busy_o
);

  localparam int ID_W  = id_w(NREQ);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e             state_q;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic [ID_W-1:0]    id_q;
  logic [2*WIDTH-1:0] prod_q;
  logic               rsp_valid_q;
  logic               busy_q;

  logic [NREQ-1:0]    gnt;
  logic [ID_W-1:0]    win_idx;
  logic               win_any;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  always_comb begin
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        op_a_d = req_a_i[i*WIDTH +: WIDTH];
        op_b_d = req_b_i[i*WIDTH +: WIDTH];
      end
    end
    rr_ptr_d    = (win_idx == ID_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    req_ready_o = (state_q == ST_IDLE) ? gnt : '0;
  end

  // Reset drops any in-flight operation; its result is never delivered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      id_q        <= '0;
      prod_q      <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_any) begin
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            id_q     <= win_idx;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= CNT_W'(LATENCY - 1);
            busy_q   <= 1'b1;
            state_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (cnt_q == '0) begin
            prod_q      <= mul_prod_i;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mul_in1_o   = op_a_q;
  assign mul_in2_o   = op_b_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = id_q;
  assign rsp_prod_o  = prod_q;
  assign busy_o      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_scheduler.sv
// ------------------------------------------------------------------
// tb_mult_scheduler: directed self-checking bench for mult_scheduler
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_mult_scheduler;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int LAT   = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [WIDTH-1:0]      mul_in1;
  logic [WIDTH-1:0]      mul_in2;
  logic [2*WIDTH-1:0]    mul_prod;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [1:0]            rsp_id;
  logic [2*WIDTH-1:0]    rsp_prod;
  logic                  busy;

  int cyc    = 0;
  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier stand-in: inputs are held for the whole run, so a
  // combinational signed product is what a LAT-cycle unit would yield.
  assign mul_prod = {{WIDTH{mul_in1[WIDTH-1]}}, mul_in1} * {{WIDTH{mul_in2[WIDTH-1]}}, mul_in2};

  mult_scheduler #(
    .NREQ    (NREQ),
    .WIDTH   (WIDTH),
    .LATENCY (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .mul_in1_o   (mul_in1),
    .mul_in2_o   (mul_in2),
    .mul_prod_i  (mul_prod),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_prod_o  (rsp_prod),
    .busy_o      (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_busy"},      64'(busy),      64'd0);
    check({tag, "_rsp_id"},    64'(rsp_id),    64'd0);
    check({tag, "_rsp_prod"},  rsp_prod,       64'd0);
    check({tag, "_mul_in1"},   64'(mul_in1),   64'd0);
    check({tag, "_mul_in2"},   64'(mul_in2),   64'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[id*WIDTH +: WIDTH] = a;
    req_b[id*WIDTH +: WIDTH] = b;
    req_valid[id]            = 1'b1;
  endtask

  // Wait for requester id to be granted, check operands on the multiplier
  // port, then wait for and check its response.
  task automatic serve(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [63:0] exp, input string tag, output int tg);
    int n;
    n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_grant"}, 64'(req_ready), 64'd1 << id);
    tg = cyc;
    tick();
    req_valid[id]            = 1'b0;
    req_a[id*WIDTH +: WIDTH] = 32'hDEAD_BEEF;
    req_b[id*WIDTH +: WIDTH] = 32'h1234_5678;
    @(negedge clk);
    check({tag, "_in1"},  64'(mul_in1), 64'(a));
    check({tag, "_in2"},  64'(mul_in2), 64'(b));
    check({tag, "_busy"}, 64'(busy),    64'd1);
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"},  64'(cyc - tg), 64'(LAT + 1));
    check({tag, "_id"},   64'(rsp_id),   64'(id));
    check({tag, "_prod"}, rsp_prod,      exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int tg0, tg1, tg2, tg3, hs, seen;
    rst       = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;

    @(negedge clk);
    check_reset("por");
    tick();
    tick();
    rst = 1'b0;

    // Single request: 2 * -5
    set_req(0, 32'd2, -32'sd5);
    serve(0, 32'd2, -32'sd5, -64'sd10, "single", tg0);

    // Clear the pointer so the all-valid burst starts at requester 0
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;

    set_req(0, -32'sd132, -32'sd5);
    set_req(1, -32'sd132, 32'sd5);
    set_req(2, 32'sd5, 32'sd0);
    set_req(3, 32'sd5, 32'sd1);
    serve(0, -32'sd132, -32'sd5, 64'sd660,  "all0", tg0);
    serve(1, -32'sd132, 32'sd5,  -64'sd660, "all1", tg1);
    serve(2, 32'sd5,    32'sd0,  64'sd0,    "all2", tg2);
    serve(3, 32'sd5,    32'sd1,  64'sd5,    "all3", tg3);
    check("gap01", 64'(tg1 - tg0), 64'(LAT + 2));
    check("gap12", 64'(tg2 - tg1), 64'(LAT + 2));
    check("gap23", 64'(tg3 - tg2), 64'(LAT + 2));

    // Fairness: after 2, both 1 and 3 pending -> 3 first
    tick();
    set_req(2, 32'sd11, -32'sd2);
    serve(2, 32'sd11, -32'sd2, -64'sd22, "rr2", tg0);
    tick();
    set_req(1, -32'sd7, -32'sd7);
    set_req(3, 32'sd100, 32'sd100);
    serve(3, 32'sd100, 32'sd100, 64'sd10000, "rr3", tg0);
    serve(1, -32'sd7, -32'sd7,   64'sd49,    "rr1", tg1);

    // Backpressure: hold rsp_ready low for 5 cycles with requester 1 waiting
    tick();
    rsp_ready = 1'b0;
    set_req(0, -32'sd8, 32'sd9);
    set_req(1, -32'sd3, 32'sd4);
    serve(0, -32'sd8, 32'sd9, -64'sd72, "bp0", tg0);
    for (int k = 0; k < 5; k++) begin
      check("bp_hold_valid", 64'(rsp_valid), 64'd1);
      check("bp_hold_id",    64'(rsp_id),    64'd0);
      check("bp_hold_prod",  rsp_prod,       -64'sd72);
      check("bp_hold_ready", 64'(req_ready), 64'd0);
      tick();
    end
    rsp_ready = 1'b1;
    hs = cyc;
    @(negedge clk);
    check("bp_hs_valid", 64'(rsp_valid), 64'd1);
    check("bp_hs_ready", 64'(req_ready), 64'd0);
    serve(1, -32'sd3, 32'sd4, -64'sd12, "bp1", tg1);
    check("bp_regrant", 64'(tg1 - hs), 64'd1);

    // Large operands
    tick();
    set_req(2, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    set_req(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    serve(2, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, "big", tg0);
    serve(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, "neg1", tg1);

    // Reset mid-RUN at t+3
    tick();
    set_req(2, 32'sd7, 32'sd3);
    seen = 0;
    @(negedge clk);
    while (req_ready == '0 && seen < 40) begin
      @(negedge clk);
      seen++;
    end
    check("abort_grant", 64'(req_ready), 64'b0100);
    tick();
    req_valid[2] = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    check_reset("midrun");
    tick();
    rst  = 1'b0;
    seen = 0;
    for (int k = 0; k < LAT + 4; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("abort_no_rsp", 64'(seen), 64'd0);
    tick();
    set_req(1, 32'sd9, -32'sd9);
    set_req(3, 32'sd6, -32'sd7);
    serve(1, 32'sd9, -32'sd9, -64'sd81, "post1", tg0);
    serve(3, 32'sd6, -32'sd7, -64'sd42, "post3", tg1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
